// File: rtl/synapse_unit_pkg.sv
// ucaspian_pkg: shared widths and the synapse entry layout
// used by synapse_unit, its output FIFO and its interface.
package ucaspian_pkg;

    localparam int SYN_ADDR_W = 10;
    localparam int WEIGHT_W   = 8;
    localparam int NEURON_W   = 8;

    typedef struct packed {
        logic signed [WEIGHT_W-1:0] weight;
        logic [NEURON_W-1:0]        target;
    } syn_entry_t;

endpackage

// File: rtl/synapse_unit_if.sv
// synapse_unit_if: address-in and dendrite-out valid/ready lanes.
// master = dispatch/dendrite side, slave = synapse_unit.
interface synapse_unit_if #(
    parameter int AW = ucaspian_pkg::SYN_ADDR_W
);

    logic                                  syn_vld;
    logic [AW-1:0]                         syn_addr;
    logic                                  syn_rdy;
    logic                                  dend_vld;
    logic signed [ucaspian_pkg::WEIGHT_W-1:0] dend_weight;
    logic [ucaspian_pkg::NEURON_W-1:0]     dend_target;
    logic                                  dend_rdy;

    modport master (
        output syn_vld, syn_addr, dend_rdy,
        input  syn_rdy, dend_vld, dend_weight, dend_target
    );

    modport slave (
        input  syn_vld, syn_addr, dend_rdy,
        output syn_rdy, dend_vld, dend_weight, dend_target
    );

endinterface

// File: rtl/syn_out_fifo.sv
// syn_out_fifo: 2-entry output buffer with 1-bit wrapping pointers.
// Ports: clk, rst_n, push/push_data, pop, occ (0..2), head (entry at read ptr).
module syn_out_fifo
    import ucaspian_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  syn_entry_t push_data,
    input  logic       pop,
    output logic [1:0] occ,
    output syn_entry_t head
);

    syn_entry_t mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic       do_push;
    logic       do_pop;

    assign do_pop  = pop && (occ != 2'd0);
    assign do_push = push && ((occ != 2'd2) || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case ({do_push, do_pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: rtl/synapse_unit.sv
// synapse_unit: address lane -> synapse RAM read -> 2-entry buffer -> dendrite lane.
// Ports: clk, reset (async active-low), enable, cfg_wr_en/cfg_addr/cfg_data,
// idle, syn (slave modport). Option: UCASPIAN_SYN_DROP_ZERO_EN drops zero weights.
module synapse_unit
    import ucaspian_pkg::*;
#(
    parameter int DEPTH      = 1024,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     cfg_wr_en,
    input  logic [$clog2(DEPTH)-1:0] cfg_addr,
    input  logic [15:0]              cfg_data,
    output logic                     idle,
    synapse_unit_if.slave            syn
);

    localparam logic [2:0] CREDITS = 3'(FIFO_DEPTH);

    syn_entry_t ram [DEPTH];
    syn_entry_t rd_q;
    syn_entry_t head;
    logic       pending;
    logic       accept;
    logic       pop;
    logic       push;
    logic [1:0] occ;
    logic [2:0] inflight;

    // Single-port RAM; contents survive reset, write wins over read.
    always_ff @(posedge clk) begin
        if (cfg_wr_en) begin
            ram[cfg_addr] <= cfg_data;
        end else if (accept) begin
            rd_q <= ram[syn.syn_addr];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending <= 1'b0;
        end else begin
            pending <= accept;
        end
    end

    // Slots claimed after this cycle: buffered + in flight - leaving.
    assign inflight = {1'b0, occ} + {2'b00, pending} - {2'b00, pop};

    assign syn.syn_rdy = reset && enable && !cfg_wr_en
                       && (inflight < CREDITS);
    assign accept      = syn.syn_vld && syn.syn_rdy;
    assign pop         = syn.dend_vld && syn.dend_rdy;

`ifdef UCASPIAN_SYN_DROP_ZERO_EN
    // Zero-weight reads retire here; their credit frees with pending.
    assign push = pending && (rd_q.weight != '0);
`else
    assign push = pending;
`endif

    syn_out_fifo u_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .push      (push),
        .push_data (rd_q),
        .pop       (pop),
        .occ       (occ),
        .head      (head)
    );

    assign syn.dend_vld    = (occ != 2'd0);
    assign syn.dend_weight = head.weight;
    assign syn.dend_target = head.target;
    assign idle            = !pending && (occ == 2'd0);

endmodule

// File: tb/tb_synapse_unit.sv
// tb_synapse_unit: directed + random stimulus against a queue-based
// reference of outstanding synapse reads.
module tb_synapse_unit;

    import ucaspian_pkg::*;

`ifdef UCASPIAN_SYN_DROP_ZERO_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        cfg_wr_en;
    logic [9:0]  cfg_addr;
    logic [15:0] cfg_data;
    logic        idle;

    synapse_unit_if bus ();

    synapse_unit dut (
        .clk       (clk),
        .reset     (rst_n),
        .enable    (enable),
        .cfg_wr_en (cfg_wr_en),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .idle      (idle),
        .syn       (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] w;
        logic [7:0] t;
        int         ready;
    } exp_t;

    exp_t        q [$];
    logic [15:0] mem_m [0:1023];
    int          cyc;
    int          checks;
    int          errors;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: check settled outputs at negedge, advance model at posedge.
    task automatic tick(output bit acc);
        bit vld;
        bit pop;
        bit rdy;
        int n;
        @(negedge clk);
        if (DROP) begin
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].ready <= cyc && q[i].w == 8'h00) q.delete(i);
            end
        end
        vld = (q.size() > 0) && (q[0].ready <= cyc);
        pop = vld && bus.dend_rdy;
        n   = q.size() - (pop ? 1 : 0);
        rdy = rst_n && enable && !cfg_wr_en && (n < 2);
        chk("syn_rdy", {15'h0, bus.syn_rdy}, {15'h0, rdy});
        chk("dend_vld", {15'h0, bus.dend_vld}, {15'h0, vld});
        chk("idle", {15'h0, idle}, {15'h0, q.size() == 0});
        if (vld) begin
            chk("dend_weight", {8'h00, bus.dend_weight}, {8'h00, q[0].w});
            chk("dend_target", {8'h00, bus.dend_target}, {8'h00, q[0].t});
        end
        acc = bus.syn_vld && rdy;
        @(posedge clk);
        cyc++;
        if (pop) void'(q.pop_front());
        if (acc) begin
            q.push_back('{mem_m[bus.syn_addr][15:8],
                          mem_m[bus.syn_addr][7:0], cyc + 1});
        end
        if (cfg_wr_en) mem_m[cfg_addr] = cfg_data;
        #1;
    endtask

    initial begin
        bit          a;
        logic [15:0] d;
        checks        = 0;
        errors        = 0;
        cyc           = 0;
        rst_n         = 1'b0;
        enable        = 1'b1;
        cfg_wr_en     = 1'b0;
        cfg_addr      = '0;
        cfg_data      = '0;
        bus.syn_vld   = 1'b0;
        bus.syn_addr  = '0;
        bus.dend_rdy  = 1'b0;

        tick(a);
        chk("rst_syn_rdy", {15'h0, bus.syn_rdy}, 16'h0);
        chk("rst_dend_vld", {15'h0, bus.dend_vld}, 16'h0);
        chk("rst_weight", {8'h00, bus.dend_weight}, 16'h0);
        chk("rst_target", {8'h00, bus.dend_target}, 16'h0);
        chk("rst_idle", {15'h0, idle}, 16'h1);

        // Program entries 0..31 while held in reset.
        cfg_wr_en = 1'b1;
        for (int i = 0; i < 32; i++) begin
            d = 16'($urandom);
            if (d[15:8] == 8'h00) d[15:8] = 8'h01;
            if (i == 5) d = 16'h1207;
            if (i == 9) d[15:8] = 8'h00;
            cfg_addr = 10'(i);
            cfg_data = d;
            tick(a);
        end
        cfg_wr_en = 1'b0;
        rst_n = 1'b1;
        tick(a);

        // Single read: latency and content.
        bus.syn_vld  = 1'b1;
        bus.syn_addr = 10'd5;
        tick(a);
        bus.syn_vld = 1'b0;
        tick(a);
        chk("lat_vld", {15'h0, bus.dend_vld}, 16'h1);
        chk("lat_weight", {8'h00, bus.dend_weight}, 16'h0012);
        chk("lat_target", {8'h00, bus.dend_target}, 16'h0007);
        bus.dend_rdy = 1'b1;
        tick(a);
        tick(a);
        chk("idle_after_pop", {15'h0, idle}, 16'h1);

        // Back-to-back 0..7 with the sink always ready.
        bus.syn_vld = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.syn_addr = 10'(i);
            tick(a);
        end
        bus.syn_vld = 1'b0;
        repeat (3) tick(a);

        // Sink stalled: buffer fills, then drains in order.
        bus.dend_rdy = 1'b0;
        bus.syn_vld  = 1'b1;
        bus.syn_addr = 10'd8;
        repeat (6) begin
            tick(a);
            if (a) bus.syn_addr = bus.syn_addr + 10'd1;
        end
        bus.syn_vld = 1'b0;
        tick(a);
        bus.dend_rdy = 1'b1;
        repeat (4) tick(a);

        // Config write blocks an accept for that cycle only.
        bus.syn_vld  = 1'b1;
        bus.syn_addr = 10'd20;
        cfg_wr_en    = 1'b1;
        cfg_addr     = 10'd21;
        cfg_data     = {8'h9c, 8'($urandom)};
        tick(a);
        cfg_wr_en = 1'b0;
        tick(a);
        bus.syn_addr = 10'd21;
        tick(a);
        bus.syn_vld = 1'b0;
        repeat (3) tick(a);

        // Reset with the buffer full.
        bus.dend_rdy = 1'b0;
        bus.syn_vld  = 1'b1;
        bus.syn_addr = 10'd1;
        repeat (4) begin
            tick(a);
            if (a) bus.syn_addr = bus.syn_addr + 10'd1;
        end
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", {15'h0, bus.dend_vld}, 16'h0);
        chk("mid_rst_idle", {15'h0, idle}, 16'h1);
        chk("mid_rst_rdy", {15'h0, bus.syn_rdy}, 16'h0);
        q.delete();
        repeat (2) tick(a);
        rst_n       = 1'b1;
        bus.syn_vld = 1'b0;
        repeat (3) tick(a);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            enable       = ($urandom_range(0, 3) != 0);
            bus.dend_rdy = ($urandom_range(0, 2) != 0);
            if (!bus.syn_vld || a) begin
                bus.syn_vld  = ($urandom_range(0, 3) != 0);
                bus.syn_addr = 10'($urandom_range(0, 31));
            end
            tick(a);
        end
        enable       = 1'b1;
        bus.syn_vld  = 1'b0;
        bus.dend_rdy = 1'b1;
        repeat (4) tick(a);

        // Zero-weight entry followed by a normal one.
        bus.dend_rdy = 1'b0;
        bus.syn_vld  = 1'b1;
        bus.syn_addr = 10'd9;
        tick(a);
        bus.syn_addr = 10'd5;
        tick(a);
        bus.syn_vld = 1'b0;
        repeat (2) tick(a);
        chk("zero_head_weight", {8'h00, bus.dend_weight},
            DROP ? 16'h0012 : 16'h0000);
        bus.dend_rdy = 1'b1;
        repeat (4) tick(a);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
